// File: rtl/kb_stream_fmt.sv
// Formats PS/2 scan codes into a UART character stream: an ASCII char or two hex digits, a
// separator, and an optional CR/LF every NL_EVERY keys. Break codes are filtered.
module kb_stream_fmt #(
  parameter int unsigned MODE         = 0,
  parameter logic [7:0]  SEP          = 8'h20,
  parameter int unsigned BREAK_FILTER = 1,
  parameter int unsigned NL_EVERY     = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_data,
  input  logic [7:0] ascii_code,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic [7:0] drop_count
);

  typedef enum logic [2:0] {StIdle, StCh0, StCh1, StSep, StCr, StLf} state_e;

  localparam logic [7:0] NlEvery = 8'(NL_EVERY);

  state_e     state_q, state_d;
  logic       break_pend_q, break_pend_d;
  logic [7:0] key_cnt_q, key_cnt_d;
  logic [7:0] code_q, code_d;
  logic [7:0] char_q, char_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] key_cnt_inc;

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign busy        = (state_q != StIdle);
  assign wr_uart     = busy && !tx_full;
  assign drop_count  = drop_cnt_q;
  assign key_cnt_inc = key_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    break_pend_d = break_pend_q;
    key_cnt_d    = key_cnt_q;
    code_d       = code_q;
    char_d       = char_q;
    drop_cnt_d   = drop_cnt_q;
    w_data       = SEP;

    unique case (state_q)
      StIdle: begin
        if (scan_done_tick) begin
          if (scan_data == 8'hF0) begin
            break_pend_d = 1'b1;
          end else if ((scan_data == 8'hE0) && (MODE == 0)) begin
            break_pend_d = break_pend_q;
          end else if (break_pend_q && (BREAK_FILTER != 0)) begin
            break_pend_d = 1'b0;
          end else begin
            break_pend_d = 1'b0;
            code_d       = scan_data;
            char_d       = ascii_code;
            state_d      = StCh0;
          end
        end
      end
      StCh0: begin
        w_data = (MODE != 0) ? hex_digit(code_q[7:4]) : char_q;
        if (wr_uart) state_d = (MODE != 0) ? StCh1 : StSep;
      end
      StCh1: begin
        w_data = hex_digit(code_q[3:0]);
        if (wr_uart) state_d = StSep;
      end
      StSep: begin
        w_data = SEP;
        if (wr_uart) begin
          if ((NL_EVERY != 0) && (key_cnt_inc == NlEvery)) begin
            key_cnt_d = 8'd0;
            state_d   = StCr;
          end else begin
            key_cnt_d = key_cnt_inc;
            state_d   = StIdle;
          end
        end
      end
      StCr: begin
        w_data = 8'h0D;
        if (wr_uart) state_d = StLf;
      end
      StLf: begin
        w_data = 8'h0A;
        if (wr_uart) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Ticks arriving mid-emission are lost; only the saturating count records them.
    if (scan_done_tick && busy && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      break_pend_q <= 1'b0;
      key_cnt_q    <= 8'd0;
      code_q       <= 8'd0;
      char_q       <= 8'd0;
      drop_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      break_pend_q <= break_pend_d;
      key_cnt_q    <= key_cnt_d;
      code_q       <= code_d;
      char_q       <= char_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_kb_stream_fmt.sv
// Randomised and directed bench for kb_stream_fmt; two differently parameterised instances
// share one stimulus stream and are checked against a byte-queue reference model.
module tb_kb_stream_fmt;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scan_done_tick = 1'b0;
  logic [7:0] scan_data = 8'h00;
  logic [7:0] ascii_code = 8'h00;
  logic       tx_full = 1'b0;

  logic       wr_a, wr_b, busy_a, busy_b;
  logic [7:0] wdata_a, wdata_b, drop_a, drop_b;

  always #5 clk = ~clk;

  kb_stream_fmt #(.MODE(0), .SEP(8'h20), .BREAK_FILTER(1), .NL_EVERY(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .scan_done_tick(scan_done_tick), .scan_data(scan_data),
    .ascii_code(ascii_code), .tx_full(tx_full), .wr_uart(wr_a), .w_data(wdata_a),
    .busy(busy_a), .drop_count(drop_a)
  );

  kb_stream_fmt #(.MODE(1), .SEP(8'h2C), .BREAK_FILTER(0), .NL_EVERY(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .scan_done_tick(scan_done_tick), .scan_data(scan_data),
    .ascii_code(ascii_code), .tx_full(tx_full), .wr_uart(wr_b), .w_data(wdata_b),
    .busy(busy_b), .drop_count(drop_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each accepted key becomes a list of bytes still owed to the UART.
  int         mode_m [2] = '{0, 1};
  int         bf_m   [2] = '{1, 0};
  int         nl_m   [2] = '{2, 3};
  logic [7:0] sep_m  [2] = '{8'h20, 8'h2C};
  logic [7:0] fifo   [2][8];
  int         cnt    [2];
  int         drops  [2];
  bit         bp     [2];
  int         kc     [2];
  string      hx = "0123456789ABCDEF";

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %02h expected %02h", tag, $time, got, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b);
    fifo[d][cnt[d]] = b;
    cnt[d]++;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0; drops[d] = 0; bp[d] = 0; kc[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic got_wr, input logic [7:0] got_data,
                            input logic got_busy, input logic [7:0] got_drop);
    bit         owed;
    logic [7:0] exp_data;
    owed     = (cnt[d] != 0);
    exp_data = owed ? fifo[d][0] : sep_m[d];
    check_eq($sformatf("wr_uart[%0d]", d), {7'd0, got_wr}, {7'd0, owed && !tx_full});
    check_eq($sformatf("w_data[%0d]", d), got_data, exp_data);
    check_eq($sformatf("busy[%0d]", d), {7'd0, got_busy}, {7'd0, owed});
    check_eq($sformatf("drop_count[%0d]", d), got_drop, 8'(drops[d]));
    if (owed && !tx_full) begin
      for (int i = 0; i < 7; i++) fifo[d][i] = fifo[d][i + 1];
      cnt[d]--;
    end
    if (scan_done_tick) begin
      if (owed) begin
        if (drops[d] < 255) drops[d]++;
      end else if (scan_data == 8'hF0) begin
        bp[d] = 1;
      end else if (scan_data == 8'hE0 && mode_m[d] == 0) begin
        bp[d] = bp[d];
      end else if (bp[d] && bf_m[d] == 1) begin
        bp[d] = 0;
      end else begin
        bp[d] = 0;
        if (mode_m[d] == 0) begin
          push(d, ascii_code);
        end else begin
          push(d, hx[scan_data / 16]);
          push(d, hx[scan_data % 16]);
        end
        push(d, sep_m[d]);
        kc[d]++;
        if (nl_m[d] != 0 && kc[d] == nl_m[d]) begin
          kc[d] = 0;
          push(d, 8'h0D);
          push(d, 8'h0A);
        end
      end
    end
  endtask

  task automatic cycle(input bit tk, input logic [7:0] sc, input logic [7:0] as, input bit full);
    scan_done_tick = tk;
    scan_data      = sc;
    ascii_code     = as;
    tx_full        = full;
    @(negedge clk);
    model_step(0, wr_a, wdata_a, busy_a, drop_a);
    model_step(1, wr_b, wdata_b, busy_b, drop_b);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    scan_done_tick = 1'b0;
    tx_full        = 1'b0;
    @(negedge clk);
    model_clear();
    model_step(0, wr_a, wdata_a, busy_a, drop_a);
    model_step(1, wr_b, wdata_b, busy_b, drop_b);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] sc;
    do_reset();
    idle(2);

    cycle(1'b1, 8'h1C, 8'h61, 1'b0);
    idle(4);
    cycle(1'b1, 8'h5A, 8'h7A, 1'b0);
    idle(5);
    cycle(1'b1, 8'hE0, 8'h00, 1'b0);
    idle(5);

    // Make, break, make: the second make is filtered only where BREAK_FILTER=1.
    cycle(1'b1, 8'h1C, 8'h61, 1'b0);
    idle(9);
    cycle(1'b1, 8'hF0, 8'h00, 1'b0);
    idle(9);
    cycle(1'b1, 8'h1C, 8'h61, 1'b0);
    idle(9);

    cycle(1'b1, 8'h1C, 8'h61, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1);
    idle(7);

    // Reset lands between the second hex digit and the separator of instance b.
    cycle(1'b1, 8'h5A, 8'h7A, 1'b0);
    idle(2);
    do_reset();
    idle(3);

    cycle(1'b1, 8'h1C, 8'h61, 1'b0);
    idle(6);
    cycle(1'b1, 8'h32, 8'h62, 1'b0);
    idle(6);
    cycle(1'b1, 8'h21, 8'h63, 1'b0);
    idle(6);

    cycle(1'b1, 8'h1C, 8'h61, 1'b1);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i), 8'h41, 1'b1);
    idle(8);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      case ($urandom_range(0, 7))
        0:       sc = 8'hF0;
        1:       sc = 8'hE0;
        default: sc = 8'($urandom);
      endcase
      cycle($urandom_range(0, 2) == 0, sc, 8'($urandom), $urandom_range(0, 3) == 0);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kb_stream_fmt.md
Name: kb_stream_fmt

Overview:
Parametrised formatter between ps2_rx and the uart transmitter.
- Turns each received scan code into a short UART character stream: an ASCII character or two uppercase hex digits, then a separator, with an optional CR/LF after every N keys.
- Filters break (key-release) sequences.
- Honours the uart tx_full back-pressure.
- Counts scan codes it had to drop because it was still busy.

Parameters:
MODE, 0, output format: 0 = ASCII char (from ascii_code input) + SEP; 1 = two hex digits of scan_data + SEP
SEP, 8'h20, separator byte sent after every key
BREAK_FILTER, 1, 1 = F0 and the following code are swallowed; 0 = F0 swallowed, following code emitted as a normal key
NL_EVERY, 16, send CR (8'h0D) LF (8'h0A) after this many emitted keys; 0 disables; legal range 0..255

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
scan_done_tick  in  1  one-cycle pulse, scan_data valid
scan_data  in  8  scan code from ps2_rx
ascii_code  in  8  key2ascii translation of scan_data, same cycle
tx_full  in  1  uart TX FIFO full
wr_uart  out  1  one-cycle write strobe to uart
w_data  out  8  character to write, valid when wr_uart=1
busy  out  1  1 whenever state != IDLE
drop_count  out  8  saturating count of scan codes dropped while busy

Behaviour:
- Reset (asynchronous, reset_n=0) values:
  - state=IDLE; wr_uart=0, w_data=SEP, busy=0, drop_count=0.
  - break_pend=0; key_cnt=0; captured code/char registers=0.
- IDLE, scan_done_tick=1, decoded in priority order:
  - scan_data=8'hF0: set break_pend, stay IDLE, nothing emitted.
  - scan_data=8'hE0 and MODE=0: discard, stay IDLE.
  - MODE=1: E0 is treated as a normal code.
  - break_pend=1 and BREAK_FILTER=1: clear break_pend, discard the byte, stay IDLE.
  - Otherwise: clear break_pend, capture scan_data and ascii_code, go to CH0.
- CH0:
  - MODE=0: emits the captured ASCII character.
  - MODE=1: emits the hex digit of bits [7:4].
  - Hex mapping: 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10).
  - Next state: MODE=1 -> CH1; MODE=0 -> SEP_S.
- CH1: emits the hex digit of bits [3:0], then SEP_S.
- SEP_S: emits SEP and increments key_cnt.
  - If NL_EVERY!=0 and the incremented value == NL_EVERY: key_cnt cleared, go to CR_S.
  - Otherwise go to IDLE.
- CR_S emits 8'h0D -> LF_S; LF_S emits 8'h0A -> IDLE.
- Emission handshake (every emitting state):
  - wr_uart is combinational: 1 iff state is an emitting state and tx_full=0.
  - The state advances only on a cycle with wr_uart=1.
  - While tx_full=1 the state holds, wr_uart=0, and w_data still shows the pending character.
- Latency: tick in cycle t -> first wr_uart in cycle t+1 if tx_full=0.
  - MODE=0 key: 2 writes on consecutive cycles.
  - MODE=1 key: 3 writes on consecutive cycles.
  - Plus 2 writes when a newline is due.
- w_data when not writing: SEP.
- Drops:
  - A scan_done_tick while state != IDLE is ignored.
  - It increments drop_count, which saturates at 8'hFF and does not wrap.
  - The dropped byte does not affect break_pend.
- key_cnt counts emitted keys only. Filtered, prefix and dropped codes do not count.
- Reset mid-emission: sequence aborted immediately, no further writes, all counters cleared.
- Implementation is fully synchronous except the reset. No combinational path from scan_done_tick to wr_uart.

Test Plan:
- MODE=0, tx_full=0: tick with scan 8'h1C, ascii 8'h61 -> wr_uart on t+1 (8'h61) and t+2 (8'h20); busy returns to 0 at t+3.
- MODE=1: tick scan 8'h5A -> writes 8'h35, 8'h41, 8'h20 on consecutive cycles; then tick scan 8'hE0 -> writes 8'h45, 8'h30, 8'h20.
- BREAK_FILTER=1, MODE=0: ticks 8'h1C, F0, 8'h1C, spaced 10 cycles -> exactly one 'a' + space; BREAK_FILTER=0 -> 'a',SP,'a',SP.
- Back-pressure: tx_full held high for 5 cycles starting at CH0 -> no wr_uart during those cycles, w_data stable; after release, full sequence emitted once, no duplicates.
- NL_EVERY=2, MODE=0: three keys -> stream a,SP,b,SP,0D,0A,c,SP; drops: 300 ticks while held busy by tx_full=1 -> drop_count=8'hFF.
- Reset: reset_n low for 1 cycle between the CH1 and SEP_S writes -> no more writes, drop_count=0, next key starts with a fresh key_cnt.
